ghash_ctrl: RTL and testbench
=============================

# ghash_ctrl

GHASH sequencing stage for AES-GCM. Accepts a stream of 128-bit blocks (AAD, ciphertext, length block), forms Y ^ X for each block, and issues it with hash subkey H to the downstream `gf128_mul`. It captures the product back as the new accumulator Y and emits the final GHASH value as the tag-input after the block flagged last. The block both feeds and consumes the multiplier, so it tolerates any multiplier latency.

## Interface
- `WIDTH`, 128, block and field width; only 128 is supported.
- `CNT_W`, 16, width of the processed-block counter.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle pulse; loads H, clears Y and the counter, and begins a message.
- `h_i` in WIDTH: hash subkey H, sampled when `start_i` is high.
- `blk_valid_i` in 1: input block valid.
- `blk_ready_o` out 1: block accepted when `blk_valid_i && blk_ready_o`.
- `blk_data_i` in WIDTH: block X.
- `blk_last_i` in 1: marks the final block of the message.
- `mul_valid_o` out 1: one-cycle request to `gf128_mul` (drives its `valid_i`).
- `mul_a_o` out WIDTH: Y ^ X, driven to multiplier `a_i`.
- `mul_b_o` out WIDTH: H, driven to multiplier `b_i`.
- `mul_valid_i` in 1: multiplier `valid_o`.
- `mul_result_i` in WIDTH: multiplier `result_o`.
- `tag_valid_o` out 1: one-cycle pulse when the GHASH result is available.
- `tag_o` out WIDTH: final Y; held until the next `start_i`.
- `busy_o` out 1: high in any state other than IDLE.
- `blk_cnt_o` out CNT_W: number of blocks whose product has been absorbed; wraps modulo 2^CNT_W.

## Operation
- States are IDLE, WAIT_BLK, MUL and DONE.
- **IDLE**: `blk_ready_o`=0. On `start_i`: H<=`h_i`, Y<=0, cnt<=0, go to WAIT_BLK.
- **WAIT_BLK**: `blk_ready_o`=1. On handshake:
  - register `mul_a_o`<=Y^`blk_data_i` and `mul_b_o`<=H;
  - latch `blk_last_i`;
  - set `mul_valid_o`<=1;
  - go to MUL.
- **MUL**: `blk_ready_o`=0.
  - `mul_valid_o` is high only in the first MUL cycle.
  - `mul_a_o` and `mul_b_o` are held stable until the result returns.
  - On `mul_valid_i`: Y<=`mul_result_i`, cnt<=cnt+1. If the latched last flag is set, go to DONE; otherwise go to WAIT_BLK.
- **DONE**: `tag_valid_o`=1 and `tag_o`=Y for exactly one cycle, then go to IDLE.
- Field arithmetic is XOR only; the multiply is external. There is no bit reordering: GCM bit order passes through unchanged.
- Boundary conditions:
  - `start_i` in any non-IDLE state aborts the message: reload H, clear Y and cnt, go to WAIT_BLK. `mul_valid_o` is dropped, and a late `mul_valid_i` from the aborted request is discarded. An abort therefore requires the multiplier to be drained, or the bench must wait out its latency before sending blocks; this is documented, not checked.
  - `mul_valid_i` outside MUL is ignored.
  - `blk_valid_i` outside WAIT_BLK is not accepted.
  - `start_i` together with `blk_valid_i` in IDLE: start wins and no block is accepted that cycle.
  - cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset values: state IDLE, and all outputs 0: `blk_ready_o`, `mul_valid_o`, `mul_a_o`, `mul_b_o`, `tag_valid_o`, `tag_o`, `busy_o`, `blk_cnt_o`. H and Y are also 0. Reset mid-message discards everything.

## Timing
- All outputs are registered, except `blk_ready_o` and `busy_o`, which are decoded from state.
- Handshake at edge T gives `mul_valid_o`=1 during cycle T..T+1.
- With multiplier latency L, meaning `mul_valid_i` is sampled L edges after `mul_valid_o` was sampled:
  - Y updates at that edge;
  - `blk_ready_o` rises in the following cycle.
- Block period is L+2 cycles minimum.
- Last block: `tag_valid_o` rises one cycle after the absorbing edge; `busy_o` falls one cycle after that.
- `en` of `gf128_mul` is tied high by the integrator; this block never stalls it.

## Test plan
- Identity: H=80000000000000000000000000000000, single last block X=0123456789abcdeffedcba9876543210 -> `mul_a_o`=X, then `tag_o`=X, `blk_cnt_o`=1.
- GCM Test Case 2 (H=66e94bd4ef8a2c3b884cfa59ca342b2e), blocks 0388dace60b6a392f328c2b971b2fe78 then length block 00000000000000000000000000000080 (last) -> `tag_o`=f38cbb1ad69223dcc3457ae5b6b0f885, exactly one `tag_valid_o` pulse.
- Latency sweep: the behavioural multiplier model at L=1, 3 and 8, with the Test Case 2 stream and `blk_valid_i` held high -> same tag each time. `blk_ready_o` is low throughout MUL, and `mul_valid_o` pulses exactly once per block.
- Abort: `start_i` with a new H while in MUL, with the old result arriving later -> the old result is ignored, Y restarts at 0, and the next message's tag matches the reference.
- Reset mid-message: assert `rst_n`=0 in MUL -> all outputs 0 immediately. After release, `blk_ready_o`=0 until `start_i`.
- Spurious/edge: `mul_valid_i` pulsed in IDLE and WAIT_BLK -> Y unchanged. With CNT_W=2, absorb 5 blocks -> `blk_cnt_o`=1.

Source files
------------

// File: rtl/ghash_ctrl_if.sv
// Block-stream and multiplier handshake bundle for ghash_ctrl.
// The slave modport is the controller's view. The master modport is the source/multiplier side.
interface ghash_ctrl_if #(
    parameter int WIDTH = 128
);
    logic             blk_valid_i;
    logic             blk_ready_o;
    logic [WIDTH-1:0] blk_data_i;
    logic             blk_last_i;
    logic             mul_valid_o;
    logic [WIDTH-1:0] mul_a_o;
    logic [WIDTH-1:0] mul_b_o;
    logic             mul_valid_i;
    logic [WIDTH-1:0] mul_result_i;

    modport master (
        output blk_valid_i, blk_data_i, blk_last_i, mul_valid_i, mul_result_i,
        input  blk_ready_o, mul_valid_o, mul_a_o, mul_b_o
    );

    modport slave (
        input  blk_valid_i, blk_data_i, blk_last_i, mul_valid_i, mul_result_i,
        output blk_ready_o, mul_valid_o, mul_a_o, mul_b_o
    );
endinterface

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: folds each block into Y, issues Y^X * H to an external gf128_mul,
// and absorbs the product. Any multiplier latency works because the block waits in MUL.
module ghash_ctrl #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] h_i,
    ghash_ctrl_if.slave      bus,
    output logic             tag_valid_o,
    output logic [WIDTH-1:0] tag_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] blk_cnt_o
);
    typedef enum logic [1:0] {IDLE, WAIT_BLK, MUL, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] y_q;
    logic             last_q;
    logic             blk_hs;
    logic             absorb;

    assign blk_hs = (state == WAIT_BLK) && bus.blk_valid_i;
    assign absorb = (state == MUL) && bus.mul_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // start_i takes priority everywhere: it begins a new message or aborts the current one.
    always_comb begin
        state_nxt = state;
        if (start_i) begin
            state_nxt = WAIT_BLK;
        end else begin
            case (state)
                WAIT_BLK: if (bus.blk_valid_i) state_nxt = MUL;
                MUL:      if (bus.mul_valid_i) state_nxt = last_q ? DONE : WAIT_BLK;
                DONE:     state_nxt = IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        bus.blk_ready_o = (state == WAIT_BLK);
        busy_o          = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            y_q         <= '0;
            last_q      <= 1'b0;
            bus.mul_valid_o <= 1'b0;
            bus.mul_a_o <= '0;
            bus.mul_b_o <= '0;
            tag_valid_o <= 1'b0;
            tag_o       <= '0;
            blk_cnt_o   <= '0;
        end else if (start_i) begin
            h_q         <= h_i;
            y_q         <= '0;
            last_q      <= 1'b0;
            bus.mul_valid_o <= 1'b0;
            tag_valid_o <= 1'b0;
            tag_o       <= '0;
            blk_cnt_o   <= '0;
        end else begin
            bus.mul_valid_o <= 1'b0;
            tag_valid_o     <= 1'b0;
            // Operands stay registered through MUL so the multiplier may sample them late.
            if (blk_hs) begin
                bus.mul_a_o     <= y_q ^ bus.blk_data_i;
                bus.mul_b_o     <= h_q;
                last_q          <= bus.blk_last_i;
                bus.mul_valid_o <= 1'b1;
            end
            if (absorb) begin
                y_q       <= bus.mul_result_i;
                blk_cnt_o <= blk_cnt_o + CNT_W'(1);
                if (last_q) begin
                    tag_valid_o <= 1'b1;
                    tag_o       <= bus.mul_result_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl with a behavioural GF(2^128) multiplier of selectable latency.
module tb_ghash_ctrl;
    localparam logic [127:0] H_ID  = {1'b1, 127'b0};
    localparam logic [127:0] X_ID  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] H_TC2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_TC2 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] L_TC2 = 128'h00000000000000000000000000000080;
    localparam logic [127:0] T_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    typedef struct {
        logic [127:0] tag;
        logic [15:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, start2;
    logic [127:0] h, h2;
    logic         tag_valid, tag_valid2, busy, busy2;
    logic [127:0] tag, tag2;
    logic [15:0]  cnt;
    logic [1:0]   cnt2;

    ghash_ctrl_if #(.WIDTH(128)) bus ();
    ghash_ctrl_if #(.WIDTH(128)) bus2 ();

    ghash_ctrl #(.WIDTH(128), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .h_i(h), .bus(bus),
        .tag_valid_o(tag_valid), .tag_o(tag), .busy_o(busy), .blk_cnt_o(cnt)
    );

    ghash_ctrl #(.WIDTH(128), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .h_i(h2), .bus(bus2),
        .tag_valid_o(tag_valid2), .tag_o(tag2), .busy_o(busy2), .blk_cnt_o(cnt2)
    );

    // GCM-order multiply: bit 127 of the vector is x^0.
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z ^= v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    int           lat = 1;
    logic [15:0]  mv_sh = '0;
    logic [127:0] md_sh [16];
    logic         spur;
    logic [127:0] spur_d;

    always @(posedge clk) begin
        mv_sh    <= {mv_sh[14:0], bus.mul_valid_o};
        md_sh[0] <= gmul(bus.mul_a_o, bus.mul_b_o);
        for (int k = 1; k < 16; k++) md_sh[k] <= md_sh[k-1];
    end
    assign bus.mul_valid_i  = mv_sh[lat-1] | spur;
    assign bus.mul_result_i = spur ? spur_d : md_sh[lat-1];

    logic         mv2 = 1'b0;
    logic [127:0] md2;
    always @(posedge clk) begin
        mv2 <= bus2.mul_valid_o;
        md2 <= gmul(bus2.mul_a_o, bus2.mul_b_o);
    end
    assign bus2.mul_valid_i  = mv2;
    assign bus2.mul_result_i = md2;

    exp_t q[$];
    exp_t q2[$];
    int   checks = 0, errors = 0;
    int   tag_pulses = 0, mul_pulses = 0, viol = 0;
    bit   outst = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && tag_valid) begin
            tag_pulses++;
            if (q.size() == 0) begin
                check("unexpected_tag", tag, 128'h0 ^ ~tag);
            end else begin
                e = q.pop_front();
                check("tag", tag, e.tag);
                check("tag_cnt", {112'h0, cnt}, {112'h0, e.cnt});
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n && tag_valid2) begin
            if (q2.size() == 0) begin
                check("unexpected_tag2", tag2, 128'h0 ^ ~tag2);
            end else begin
                e = q2.pop_front();
                check("tag2", tag2, e.tag);
                check("tag2_cnt", {126'h0, cnt2}, {112'h0, e.cnt});
            end
        end
    end

    // Tracks an outstanding multiply so blk_ready_o can be checked against it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mul_valid_o) begin
                mul_pulses++;
                outst = 1'b1;
            end
            if (outst && bus.blk_ready_o) viol++;
            if (bus.mul_valid_i) outst = 1'b0;
        end else begin
            outst = 1'b0;
        end
    end

    task automatic do_start(input logic [127:0] hv);
        @(negedge clk);
        start = 1'b1;
        h     = hv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_lat(input int l);
        repeat (20) @(negedge clk);
        lat = l;
    endtask

    task automatic send_blk(input logic [127:0] d, input logic last, input logic hold);
        bit got = 1'b0;
        @(negedge clk);
        bus.blk_valid_i = 1'b1;
        bus.blk_data_i  = d;
        bus.blk_last_i  = last;
        for (int c = 0; c < 200; c++) begin
            if (bus.blk_ready_o) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("blk_handshake", {127'h0, got}, 128'h1);
        @(posedge clk);
        #1;
        if (!hold) bus.blk_valid_i = 1'b0;
    endtask

    task automatic send_blk2(input logic [127:0] d, input logic last);
        bit got = 1'b0;
        @(negedge clk);
        bus2.blk_valid_i = 1'b1;
        bus2.blk_data_i  = d;
        bus2.blk_last_i  = last;
        for (int c = 0; c < 200; c++) begin
            if (bus2.blk_ready_o) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("blk2_handshake", {127'h0, got}, 128'h1);
        @(posedge clk);
        #1;
        bus2.blk_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit second);
        bit got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!(second ? busy2 : busy)) begin got = 1'b1; break; end
        end
        check(name, {127'h0, got}, 128'h1);
    endtask

    task automatic spur_pulse();
        @(negedge clk);
        spur   = 1'b1;
        spur_d = 128'hdeadbeefcafef00d5555aaaa12345678;
        @(negedge clk);
        spur   = 1'b0;
    endtask

    task automatic check_all_zero(input string tagname);
        check({tagname, "_ready"},   {127'h0, bus.blk_ready_o}, 128'h0);
        check({tagname, "_mvalid"},  {127'h0, bus.mul_valid_o}, 128'h0);
        check({tagname, "_mul_a"},   bus.mul_a_o, 128'h0);
        check({tagname, "_mul_b"},   bus.mul_b_o, 128'h0);
        check({tagname, "_tvalid"},  {127'h0, tag_valid}, 128'h0);
        check({tagname, "_tag"},     tag, 128'h0);
        check({tagname, "_busy"},    {127'h0, busy}, 128'h0);
        check({tagname, "_cnt"},     {112'h0, cnt}, 128'h0);
    endtask

    initial begin
        int rdy_seen;
        int lats[3] = '{1, 3, 8};
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; h = '0; h2 = '0;
        spur = 1'b0; spur_d = '0;
        bus.blk_valid_i  = 1'b0; bus.blk_data_i  = '0; bus.blk_last_i  = 1'b0;
        bus2.blk_valid_i = 1'b0; bus2.blk_data_i = '0; bus2.blk_last_i = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Identity subkey: product equals its input.
        lat = 3;
        do_start(H_ID);
        q.push_back('{X_ID, 16'd1});
        tag_pulses = 0;
        send_blk(X_ID, 1'b1, 1'b0);
        check("id_mul_a", bus.mul_a_o, X_ID);
        check("id_mul_b", bus.mul_b_o, H_ID);
        check("id_mul_valid", {127'h0, bus.mul_valid_o}, 128'h1);
        wait_idle("id_idle", 1'b0);
        check("id_pulses", 128'(tag_pulses), 128'd1);

        foreach (lats[i]) begin
            set_lat(lats[i]);
            tag_pulses = 0; mul_pulses = 0; viol = 0;
            do_start(H_TC2);
            q.push_back('{T_TC2, 16'd2});
            send_blk(C_TC2, 1'b0, 1'b1);
            send_blk(L_TC2, 1'b1, 1'b0);
            wait_idle("sweep_idle", 1'b0);
            check("sweep_tag_pulses", 128'(tag_pulses), 128'd1);
            check("sweep_mul_pulses", 128'(mul_pulses), 128'd2);
            check("sweep_ready_in_mul", 128'(viol), 128'd0);
        end

        // Abort while the multiply is in flight; its result lands during WAIT_BLK.
        set_lat(8);
        do_start(H_ID);
        send_blk(X_ID, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        do_start(H_TC2);
        check("abort_mvalid", {127'h0, bus.mul_valid_o}, 128'h0);
        check("abort_cnt", {112'h0, cnt}, 128'h0);
        check("abort_ready", {127'h0, bus.blk_ready_o}, 128'h1);
        repeat (12) @(negedge clk);
        tag_pulses = 0;
        q.push_back('{T_TC2, 16'd2});
        send_blk(C_TC2, 1'b0, 1'b1);
        send_blk(L_TC2, 1'b1, 1'b0);
        wait_idle("abort_idle", 1'b0);
        check("abort_pulses", 128'(tag_pulses), 128'd1);

        // Reset during MUL.
        do_start(H_TC2);
        send_blk(C_TC2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.blk_valid_i = 1'b1;
        rdy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.blk_ready_o || busy) rdy_seen++;
        end
        bus.blk_valid_i = 1'b0;
        check("postrst_ready", 128'(rdy_seen), 128'd0);

        // Spurious multiplier results in IDLE and WAIT_BLK.
        set_lat(1);
        spur_pulse();
        check("spur_idle_cnt", {112'h0, cnt}, 128'h0);
        check("spur_idle_busy", {127'h0, busy}, 128'h0);
        do_start(H_ID);
        spur_pulse();
        check("spur_wait_cnt", {112'h0, cnt}, 128'h0);
        q.push_back('{X_ID, 16'd1});
        send_blk(X_ID, 1'b1, 1'b0);
        wait_idle("spur_idle", 1'b0);

        // Two-bit counter wraps: five blocks leave it at 1.
        @(negedge clk);
        start2 = 1'b1; h2 = H_ID;
        @(negedge clk);
        start2 = 1'b0;
        q2.push_back('{128'h1f, 16'd1});
        send_blk2(128'h01, 1'b0);
        send_blk2(128'h02, 1'b0);
        send_blk2(128'h04, 1'b0);
        send_blk2(128'h08, 1'b0);
        send_blk2(128'h10, 1'b1);
        wait_idle("wrap_idle", 1'b1);

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(q.size()), 128'd0);
        check("sb2_drained", 128'(q2.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
